// File: rtl/pc_gen_if.sv
// Fetch-stage PC generator bus: redirect requests in, PC views out.
// The master side drives stall and redirects; the slave (pc_gen) returns the PCs.
interface pc_gen_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             branch;
    logic [WIDTH-1:0] pc_branch;
    logic             jump;
    logic [WIDTH-1:0] pc_jump;
    logic             jr;
    logic [WIDTH-1:0] pc_jr;
    logic             exc;
    logic             eret;
    logic [WIDTH-1:0] epc;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic [WIDTH-1:0] npc;
    logic             redirect_pending;

    modport master (
        output stall, branch, pc_branch, jump, pc_jump, jr, pc_jr, exc, eret, epc,
        input  pc, pc_plus, npc, redirect_pending
    );

    modport slave (
        input  stall, branch, pc_branch, jump, pc_jump, jr, pc_jr, exc, eret, epc,
        output pc, pc_plus, npc, redirect_pending
    );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: prioritised redirects, fetch stall, and a one-entry
// pending buffer so a redirect seen during a stall is applied on release.
module pc_gen #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_PC   = WIDTH'(32'h0000_4180),
    parameter int               INC      = 4
) (
    input  logic      clk,
    input  logic      rst,
    pc_gen_if.slave   bus
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;
    logic             pend_exc_q, pend_exc_d;

    logic             req;
    logic             req_exc;
    logic [WIDTH-1:0] req_target;
    logic [WIDTH-1:0] pc_plus;
    logic [WIDTH-1:0] npc;

    // Fixed priority: exc > eret > branch > jump > jr.
    // NOTE: every combinational output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        req        = 1'b1;
        req_exc    = 1'b0;
        req_target = '0;
        if (bus.exc) begin
            req_exc    = 1'b1;
            req_target = EXC_PC;
        end else if (bus.eret) begin
            req_target = bus.epc;
        end else if (bus.branch) begin
            req_target = bus.pc_branch;
        end else if (bus.jump) begin
            req_target = bus.pc_jump;
        end else if (bus.jr) begin
            req_target = bus.pc_jr;
        end else begin
            req = 1'b0;
        end
    end

    assign pc_plus = pc_q + WIDTH'(INC);

    // A live exception beats everything; a pending exception beats any other live request.
    always_comb begin
        npc = pc_plus;
        if (req && req_exc) begin
            npc = EXC_PC;
        end else if (pend_valid_q && pend_exc_q) begin
            npc = pend_target_q;
        end else if (req) begin
            npc = req_target;
        end else if (pend_valid_q) begin
            npc = pend_target_q;
        end
    end

    always_comb begin
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        pend_exc_d    = pend_exc_q;
        if (!bus.stall) begin
            pc_d          = npc;
            pend_valid_d  = 1'b0;
            pend_target_d = '0;
            pend_exc_d    = 1'b0;
        end else if (req && !(pend_valid_q && pend_exc_q && !req_exc)) begin
            // Non-exception requests overwrite each other (latest wins) but never a pending exception.
            pend_valid_d  = 1'b1;
            pend_target_d = req_target;
            pend_exc_d    = req_exc;
        end
    end

    // NOTE: state flops use non-blocking assignments and the asynchronous reset
    // clears the pending entry as well as the PC, so a stalled redirect cannot survive reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            pend_exc_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            pend_exc_q    <= pend_exc_d;
        end
    end

    assign bus.pc               = pc_q;
    assign bus.pc_plus          = pc_plus;
    assign bus.npc              = npc;
    assign bus.redirect_pending = pend_valid_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, reset/wrap sequences,
// and randomized traffic against a behavioural model of the redirect rules.
module tb_pc_gen;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_V  = 32'h0000_4180;

    logic clk;
    logic rst;

    pc_gen_if #(.WIDTH(32)) bus ();
    pc_gen_if #(.WIDTH(8))  sbus ();

    pc_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pc_gen #(
        .WIDTH    (8),
        .RESET_PC (8'hFC),
        .EXC_PC   (8'h80),
        .INC      (4)
    ) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        branch;
        logic [31:0] pc_branch;
        logic        jump;
        logic [31:0] pc_jump;
        logic        jr;
        logic [31:0] pc_jr;
        logic        exc;
        logic        eret;
        logic [31:0] epc;
        logic [31:0] exp_pc;
        logic        exp_pend;
    } vec_t;

    typedef struct {
        logic [31:0] target;
        logic        is_exc;
    } redir_t;

    task automatic drive_idle();
        bus.stall = 1'b0; bus.branch = 1'b0; bus.pc_branch = '0;
        bus.jump = 1'b0; bus.pc_jump = '0; bus.jr = 1'b0; bus.pc_jr = '0;
        bus.exc = 1'b0; bus.eret = 1'b0; bus.epc = '0;
    endtask

    task automatic apply_vec(input vec_t v);
        bus.stall = v.stall; bus.branch = v.branch; bus.pc_branch = v.pc_branch;
        bus.jump = v.jump; bus.pc_jump = v.pc_jump; bus.jr = v.jr; bus.pc_jr = v.pc_jr;
        bus.exc = v.exc; bus.eret = v.eret; bus.epc = v.epc;
    endtask

    // Reference: pick the winning request from an ordered candidate list, then
    // apply the selection and buffering rules on plain variables.
    logic [31:0] m_pc;
    redir_t      m_pend[$];

    function automatic logic [31:0] model_npc(output logic have_req, output redir_t r);
        redir_t cands[$];
        logic [31:0] n;
        if (bus.exc)    cands.push_back('{EXC_V, 1'b1});
        if (bus.eret)   cands.push_back('{bus.epc, 1'b0});
        if (bus.branch) cands.push_back('{bus.pc_branch, 1'b0});
        if (bus.jump)   cands.push_back('{bus.pc_jump, 1'b0});
        if (bus.jr)     cands.push_back('{bus.pc_jr, 1'b0});
        have_req = (cands.size() != 0);
        r = have_req ? cands[0] : '{32'h0, 1'b0};
        if (have_req && r.is_exc)                     n = EXC_V;
        else if (m_pend.size() != 0 && m_pend[0].is_exc) n = m_pend[0].target;
        else if (have_req)                            n = r.target;
        else if (m_pend.size() != 0)                  n = m_pend[0].target;
        else                                          n = m_pc + 32'd4;
        return n;
    endfunction

    vec_t vecs[24];

    initial begin
        logic        have_req;
        redir_t      r;
        logic [31:0] exp_npc;

        vecs[0]  = '{0, 0, 0,        0, 0,        0, 0,        0, 0, 0,        32'h3004, 0};
        vecs[1]  = '{0, 0, 0,        0, 0,        0, 0,        0, 0, 0,        32'h3008, 0};
        vecs[2]  = '{0, 0, 0,        0, 0,        0, 0,        0, 0, 0,        32'h300C, 0};
        vecs[3]  = '{0, 0, 0,        0, 0,        0, 0,        0, 0, 0,        32'h3010, 0};
        vecs[4]  = '{0, 1, 32'h3100, 1, 32'h3200, 0, 0,        0, 0, 0,        32'h3100, 0};
        vecs[5]  = '{0, 0, 0,        0, 0,        0, 0,        1, 1, 32'h3050, 32'h4180, 0};
        vecs[6]  = '{1, 0, 0,        1, 32'h3400, 0, 0,        0, 0, 0,        32'h4180, 1};
        vecs[7]  = '{1, 0, 0,        0, 0,        0, 0,        0, 0, 0,        32'h4180, 1};
        vecs[8]  = '{1, 0, 0,        0, 0,        0, 0,        0, 0, 0,        32'h4180, 1};
        vecs[9]  = '{0, 0, 0,        0, 0,        0, 0,        0, 0, 0,        32'h3400, 0};
        vecs[10] = '{1, 0, 0,        0, 0,        0, 0,        1, 0, 0,        32'h3400, 1};
        vecs[11] = '{1, 0, 0,        0, 0,        1, 32'h3500, 0, 0, 0,        32'h3400, 1};
        vecs[12] = '{0, 0, 0,        0, 0,        0, 0,        0, 0, 0,        32'h4180, 0};
        vecs[13] = '{1, 0, 0,        0, 0,        1, 32'h3500, 0, 0, 0,        32'h4180, 1};
        vecs[14] = '{1, 0, 0,        0, 0,        0, 0,        1, 0, 0,        32'h4180, 1};
        vecs[15] = '{0, 0, 0,        0, 0,        0, 0,        0, 0, 0,        32'h4180, 0};
        vecs[16] = '{1, 1, 32'h3600, 0, 0,        0, 0,        0, 0, 0,        32'h4180, 1};
        vecs[17] = '{1, 0, 0,        1, 32'h3700, 0, 0,        0, 0, 0,        32'h4180, 1};
        vecs[18] = '{0, 0, 0,        0, 0,        0, 0,        0, 0, 0,        32'h3700, 0};
        vecs[19] = '{1, 0, 0,        0, 0,        1, 32'h3800, 0, 0, 0,        32'h3700, 1};
        vecs[20] = '{0, 1, 32'h3900, 0, 0,        0, 0,        0, 0, 0,        32'h3900, 0};
        vecs[21] = '{1, 0, 0,        0, 0,        0, 0,        1, 0, 0,        32'h3900, 1};
        vecs[22] = '{0, 0, 0,        1, 32'h3A00, 0, 0,        0, 0, 0,        32'h4180, 0};
        vecs[23] = '{0, 0, 0,        0, 0,        0, 0,        0, 0, 0,        32'h4184, 0};

        drive_idle();
        sbus.stall = 1'b0; sbus.branch = 1'b0; sbus.pc_branch = '0;
        sbus.jump = 1'b0; sbus.pc_jump = '0; sbus.jr = 1'b0; sbus.pc_jr = '0;
        sbus.exc = 1'b0; sbus.eret = 1'b0; sbus.epc = '0;
        rst = 1'b1;

        #2;
        check("reset_pc", bus.pc, RST_PC);
        check("reset_pend", 32'(bus.redirect_pending), 32'd0);
        check("reset_pc_plus", bus.pc_plus, 32'h3004);
        check("reset_npc", bus.npc, 32'h3004);
        check("wrap_reset_pc", 32'(sbus.pc), 32'h0000_00FC);
        check("wrap_pc_plus", 32'(sbus.pc_plus), 32'h0000_0000);

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            apply_vec(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_pc", i), bus.pc, vecs[i].exp_pc);
            check($sformatf("vec%0d_pend", i), 32'(bus.redirect_pending), 32'(vecs[i].exp_pend));
            if (i == 0) check("wrap_pc_after_edge", 32'(sbus.pc), 32'h0000_0000);
        end

        // Asynchronous reset while a redirect sits in the pending buffer.
        drive_idle();
        bus.stall = 1'b1; bus.jump = 1'b1; bus.pc_jump = 32'h3800;
        @(posedge clk);
        #1;
        check("midrst_pend_before", 32'(bus.redirect_pending), 32'd1);
        check("midrst_pc_before", bus.pc, 32'h4184);
        bus.jump = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("midrst_pc", bus.pc, RST_PC);
        check("midrst_pend", 32'(bus.redirect_pending), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.stall = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_release_pc", bus.pc, 32'h3004);
        check("midrst_release_pend", 32'(bus.redirect_pending), 32'd0);

        // Randomized traffic against the model.
        m_pc = 32'h3004;
        m_pend.delete();
        for (int c = 0; c < 400; c++) begin
            bus.stall     = ($urandom_range(0, 9) < 4);
            bus.exc       = ($urandom_range(0, 15) == 0);
            bus.eret      = ($urandom_range(0, 9) == 0);
            bus.branch    = ($urandom_range(0, 5) == 0);
            bus.jump      = ($urandom_range(0, 6) == 0);
            bus.jr        = ($urandom_range(0, 7) == 0);
            bus.epc       = $urandom;
            bus.pc_branch = $urandom;
            bus.pc_jump   = $urandom;
            bus.pc_jr     = $urandom;
            #1;
            exp_npc = model_npc(have_req, r);
            check("rand_npc", bus.npc, exp_npc);
            check("rand_pc_plus", bus.pc_plus, m_pc + 32'd4);
            if (!bus.stall) begin
                m_pc = exp_npc;
                m_pend.delete();
            end else if (have_req && !(m_pend.size() != 0 && m_pend[0].is_exc && !r.is_exc)) begin
                m_pend.delete();
                m_pend.push_back(r);
            end
            @(posedge clk);
            #1;
            check("rand_pc", bus.pc, m_pc);
            check("rand_pend", 32'(bus.redirect_pending), 32'(m_pend.size() != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage of the pipelined CPU. It holds the PC register, selects the next PC from sequential, branch, jump, register-jump, exception and exception-return sources with fixed priority, and honours a fetch stall. A redirect that arrives during a stall is captured in a one-entry pending buffer and applied on the first unstalled cycle, so it is never lost.

## Interface
- WIDTH, 32, PC and target width in bits
- RESET_PC, 32'h0000_3000, PC value on reset
- EXC_PC, 32'h0000_4180, exception vector
- INC, 4, sequential increment
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  fetch stall; PC holds while high
- branch  in  1  taken-branch redirect request
- pc_branch  in  WIDTH  branch target
- jump  in  1  jump redirect request (j/jal)
- pc_jump  in  WIDTH  jump target
- jr  in  1  register-jump redirect request
- pc_jr  in  WIDTH  register-jump target
- exc  in  1  exception request, target EXC_PC
- eret  in  1  exception-return request
- epc  in  WIDTH  exception-return target
- pc  out  WIDTH  current PC (registered)
- pc_plus  out  WIDTH  pc + INC (combinational)
- npc  out  WIDTH  value pc loads at next unstalled edge (combinational)
- redirect_pending  out  1  pending buffer holds a captured redirect

## Operation
- Request priority in one cycle: exc > eret > branch > jump > jr. The highest asserted request is "this cycle's request" (req, target, is_exc = exc).
- Pending buffer: pend_valid, pend_target, pend_exc. Reset: all cleared.
- Selection for npc:
  - req with is_exc -> EXC_PC.
  - else pend_valid and pend_exc -> pend_target.
  - else req -> its target.
  - else pend_valid -> pend_target.
  - else pc + INC.
- stall = 0: pc <= npc; pending buffer cleared.
- stall = 1: pc holds. If req: load buffer with (target, is_exc) unless buffer holds pend_exc and req is not exc; a non-exc req overwrites a non-exc pending entry (latest wins). No req: buffer unchanged.
- pc_plus = pc + INC, modulo 2^WIDTH (wraps, no carry out). Targets used unmodified; no alignment forcing.
- redirect_pending = pend_valid.

## Timing
- Reset (async): pc = RESET_PC immediately; pend_valid = 0, redirect_pending = 0; pc_plus = RESET_PC + INC, npc = RESET_PC + INC once requests are low.
- First rising edge after rst deasserts with stall = 0: pc = RESET_PC + INC.
- Redirect latency: request sampled at edge n with stall = 0 -> pc = target after edge n.
- Redirect during stall: captured at edge n; redirect_pending high after edge n; pc = target after first edge with stall = 0; redirect_pending low after that same edge.
- Request on the releasing cycle (stall = 0) combines with pending per the selection rules; buffer always cleared that edge.
- Reset mid-stall with pending entry: entry discarded; pc = RESET_PC.
- npc, pc_plus are combinational from pc, pending state and inputs; no input-to-pc combinational path except through the register.

## Test plan
- Reset/sequential: rst pulse, 3 unstalled cycles -> pc 0x3000, 0x3004, 0x3008, 0x300C; redirect_pending 0.
- Priority: pc = 0x3010, branch=1 pc_branch=0x3100 and jump=1 pc_jump=0x3200 same cycle -> pc = 0x3100; then exc=1 with eret=1 epc=0x3050 -> pc = 0x4180.
- Stall capture: stall=1, jump=1 pc_jump=0x3400 one cycle, jump=0, stall held 2 more cycles -> pc constant, redirect_pending 1; stall=0 -> pc = 0x3400, redirect_pending 0.
- Exception protection: stall=1, exc=1 one cycle, then jr=1 pc_jr=0x3500 -> pending remains EXC_PC; release -> pc = 0x4180. Reverse order (jr then exc) -> 0x4180.
- Latest-wins and wrap: stall=1, branch to 0x3600 then jump to 0x3700 -> release gives 0x3700; with WIDTH=8, INC=4, pc=8'hFC unstalled -> pc = 8'h00.
- Reset mid-operation: stall=1 with pending 0x3800, assert rst asynchronously mid-cycle -> pc = 0x3000 immediately, redirect_pending 0; after release, pc = 0x3004.
